alu_add_and_or: RTL and testbench

// - Registered 64-bit execute-stage unit: bitwise AND, bitwise OR, and ADD with carry-in.
// - Produces zero, carry (unsigned out-of-range) and overflow (signed out-of-range) flags.
// - Sits in the Execute stage; the ALU control decoder drives it and writeback consumes it.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/full_adder.sv | 16 +
 rtl/alu_add_and_or.sv | 93 +++++++++
 tb/tb_alu_add_and_or.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings for the execute stage.
// Only AND/OR/ADD are implemented today; the remaining codes are reserved.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0010;

    // Reserved for future operations; decoded as invalid by this unit.
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1001;

    function automatic logic alu_op_defined(input logic [ALU_CTRL_W-1:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; chained by the ALU into a ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/alu_add_and_or.sv
// Registered execute-stage ALU: AND, OR and ADD-with-carry, with zero/carry/overflow
// flags and an invalid-op indicator. One cycle of latency, output registers only.
module alu_add_and_or
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [ALU_CTRL_W-1:0] control,
    input  logic [WIDTH-1:0]      rs1,
    input  logic [WIDTH-1:0]      rs2,
    input  logic                  cin,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      rd,
    output logic                  zero,
    output logic                  carry,
    output logic                  overflow,
    output logic                  op_invalid
);

    // Valid semantics: no backpressure. in_valid=1 at a rising edge captures the
    // operation; out_valid follows one cycle later. in_valid=0 holds rd and flags.

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            full_adder u_fa (
                .a  (rs1[i]),
                .b  (rs2[i]),
                .ci (c[i]),
                .s  (sum[i]),
                .co (c[i+1])
            );
            assign and_res[i] = rs1[i] & rs2[i];
            assign or_res[i]  = rs1[i] | rs2[i];
        end
    endgenerate

    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;
    logic             res_inv;
    logic             res_zero;

    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_inv   = 1'b0;
        case (control)
            ALU_AND: res = and_res;
            ALU_OR:  res = or_res;
            ALU_ADD: begin
                res       = sum;
                res_carry = c[WIDTH];
                // Signed overflow: carry into the MSB differs from carry out of it.
                res_ovf   = c[WIDTH-1] ^ c[WIDTH];
            end
            default: res_inv = 1'b1;
        endcase
        res_zero = (res == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            rd         <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            op_invalid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                rd         <= res;
                zero       <= res_zero;
                carry      <= res_carry;
                overflow   <= res_ovf;
                op_invalid <= res_inv;
            end
        end
    end

endmodule

// File: tb/tb_alu_add_and_or.sv
// Bench for alu_add_and_or: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_alu_add_and_or;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [3:0]   control;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] rd;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         op_invalid;

    alu_add_and_or #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .control    (control),
        .rs1        (rs1),
        .rs2        (rs2),
        .cin        (cin),
        .out_valid  (out_valid),
        .rd         (rd),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .op_invalid (op_invalid)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: what the outputs should show right now.
    logic         m_valid;
    logic [W-1:0] m_rd;
    logic         m_zero;
    logic         m_carry;
    logic         m_ovf;
    logic         m_inv;

    // Expected results of ops in flight, consumed one per cycle.
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_rd    = '0;
        m_zero  = 1'b0;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        m_inv   = 1'b0;
        exp_q.delete();
    endtask

    // Behavioural ALU: wide-integer arithmetic, signed range test for overflow.
    task automatic model_op(input logic [3:0] ctrl, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic ci);
        logic [W:0]          u;
        logic signed [W+1:0] s;
        logic signed [W+1:0] smax;
        logic signed [W+1:0] smin;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        m_inv   = 1'b0;
        case (ctrl)
            4'd0: m_rd = a & b;
            4'd1: m_rd = a | b;
            4'd2: begin
                u       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                m_rd    = u[W-1:0];
                m_carry = u[W];
                s       = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b})
                          + $signed({{(W+1){1'b0}}, ci});
                smax    = $signed({3'b000, {(W-1){1'b1}}});
                smin    = -smax - 1;
                m_ovf   = (s > smax) || (s < smin);
            end
            default: begin
                m_rd  = '0;
                m_inv = 1'b1;
            end
        endcase
        m_zero = (m_rd == '0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"},  {{(W-1){1'b0}}, out_valid},  {{(W-1){1'b0}}, m_valid});
        check({tag, ".rd"},         rd,                          m_rd);
        check({tag, ".zero"},       {{(W-1){1'b0}}, zero},       {{(W-1){1'b0}}, m_zero});
        check({tag, ".carry"},      {{(W-1){1'b0}}, carry},      {{(W-1){1'b0}}, m_carry});
        check({tag, ".overflow"},   {{(W-1){1'b0}}, overflow},   {{(W-1){1'b0}}, m_ovf});
        check({tag, ".op_invalid"}, {{(W-1){1'b0}}, op_invalid}, {{(W-1){1'b0}}, m_inv});
    endtask

    // Driver: called just after a falling edge; drives one cycle, checks at the next fall.
    task automatic issue(input string tag, input logic v, input logic [3:0] ctrl,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        in_valid = v;
        control  = ctrl;
        rs1      = a;
        rs2      = b;
        cin      = ci;
        @(posedge clk);
        m_valid = v;
        if (v) model_op(ctrl, a, b, ci);
        @(negedge clk);
        check_outputs(tag);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] r;
        case ($urandom_range(0, 5))
            0: r = '1;
            1: r = '0;
            2: r = {1'b1, {(W-1){1'b0}}};
            3: r = {1'b0, {(W-1){1'b1}}};
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    // Directed expected values, held in variables for explicit comparisons.
    logic [W-1:0] e_and;
    logic [W-1:0] e_or;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        control  = '0;
        rs1      = '0;
        rs2      = '0;
        cin      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // AND / OR pattern
        e_and = 64'h00F0_0000_0000_0F0F;
        e_or  = 64'hFFF0_FFFF_FFFF_FFFF;
        issue("and_pat", 1'b1, 4'b0000, 64'hF0F0_0000_FFFF_0F0F, 64'h0FF0_FFFF_0000_FFFF, 1'b1);
        check("and_pat.const", rd, e_and);
        issue("or_pat", 1'b1, 4'b0001, 64'hF0F0_0000_FFFF_0F0F, 64'h0FF0_FFFF_0000_FFFF, 1'b0);
        check("or_pat.const", rd, e_or);
        issue("and_zero", 1'b1, 4'b0000, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
        check("and_zero.const", {63'b0, zero}, 64'd1);

        // ADD basics and corner cases
        issue("add_5_7", 1'b1, 4'b0010, 64'd5, 64'd7, 1'b0);
        check("add_5_7.const", rd, 64'd12);
        issue("add_5_7_c", 1'b1, 4'b0010, 64'd5, 64'd7, 1'b1);
        check("add_5_7_c.const", rd, 64'd13);
        issue("add_m3_3", 1'b1, 4'b0010, -64'sd3, 64'd3, 1'b0);
        check("add_m3_3.carry", {63'b0, carry}, 64'd1);
        issue("add_ovf_pos", 1'b1, 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check("add_ovf_pos.ovf", {63'b0, overflow}, 64'd1);
        check("add_ovf_pos.rd", rd, 64'h8000_0000_0000_0000);
        issue("add_ovf_neg", 1'b1, 4'b0010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        check("add_ovf_neg.ovf", {63'b0, overflow}, 64'd1);

        // Back-to-back then a gap: rd must hold, out_valid drops
        issue("b2b_and", 1'b1, 4'b0000, 64'hFF00, 64'h0FF0, 1'b0);
        issue("b2b_or",  1'b1, 4'b0001, 64'hFF00, 64'h0FF0, 1'b0);
        issue("b2b_add", 1'b1, 4'b0010, 64'hFF00, 64'h0FF0, 1'b1);
        issue("gap",     1'b0, 4'b0000, 64'd0, 64'd0, 1'b0);
        check("gap.rd_held", rd, 64'h1_0EF1);

        // Invalid op, then a valid op clears op_invalid
        issue("invalid", 1'b1, 4'b1111, 64'd1, 64'd1, 1'b0);
        check("invalid.const", {63'b0, op_invalid}, 64'd1);
        issue("after_inv", 1'b1, 4'b0001, 64'd1, 64'd2, 1'b0);

        // Reset mid-stream: outputs clear without a clock edge
        issue("pre_rst", 1'b1, 4'b0010, 64'd100, 64'd23, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst_idle", 1'b0, 4'b0010, 64'd9, 64'd9, 1'b0);
        issue("post_rst_op", 1'b1, 4'b0010, 64'd9, 64'd9, 1'b0);

        // Randomized operations
        for (int k = 0; k < 300; k++) begin
            logic [3:0] ctrl;
            ctrl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15))
                                                : 4'($urandom_range(0, 2));
            issue("rand", ($urandom_range(0, 4) != 0), ctrl,
                  pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
